// File: rtl/wasca_pio_pkg.sv
// =====================================================================
// wasca_pio_pkg : register map and helpers for the WASCA key PIO
// Rev 1.0
// =====================================================================
`default_nettype none

package wasca_pio_pkg;

   typedef logic [1:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA = 2'd0;
   localparam pio_addr_t ADDR_RSVD = 2'd1;
   localparam pio_addr_t ADDR_MASK = 2'd2;
   localparam pio_addr_t ADDR_EDGE = 2'd3;

   localparam int unsigned DATA_W = 32;

   // Counter must hold 0..cycles inclusive.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/wasca_debounce.sv
// =====================================================================
// wasca_debounce : 2-flop synchronizer plus stable-level debouncer, one bit
// Rev 1.0
// =====================================================================
`default_nettype none

module wasca_debounce
   import wasca_pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic change
);

   localparam int unsigned           c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_stable;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_differs;
   logic               w_done;

   assign w_differs = (r_sync2 != r_stable);
   // The count completes on the edge where it would otherwise reach DEBOUNCE_CYCLES.
   assign w_done    = w_differs && (r_cnt == c_cnt_last);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1  <= RESET_LEVEL;
         r_sync2  <= RESET_LEVEL;
         r_stable <= RESET_LEVEL;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (!w_differs || w_done) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_done) begin
            r_stable <= r_sync2;
         end
      end
   end

   assign dout = r_stable;
   // High during the cycle whose closing edge flips dout.
   assign change = w_done;

endmodule

`default_nettype wire

// File: rtl/wasca_keys_pio.sv
// =====================================================================
// wasca_keys_pio : debounced push-button PIO with edge capture, Avalon-MM
// Rev 1.0
// =====================================================================
`default_nettype none

module wasca_keys_pio
   import wasca_pio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
   parameter bit               CAPTURE_FALLING = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_change;
   logic [WIDTH-1:0] w_capture;
   logic [WIDTH-1:0] w_clear;
   logic             w_write;
   logic [31:0]      w_rd;
   logic             w_unused_wdata;

   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_capture;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
         wasca_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[gi])
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[gi]),
            .dout    (w_stable[gi]),
            .change  (w_change[gi])
         );
         // Current level tells the direction of the pending flip.
         assign w_capture[gi] = w_change[gi] &
                                (CAPTURE_FALLING ? w_stable[gi] : ~w_stable[gi]);
      end
   endgenerate

   assign w_write = chipselect && !write_n;
   assign w_clear = (w_write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_irq_mask     <= '0;
         r_edge_capture <= '0;
      end else begin
         if (w_write && (address == ADDR_MASK)) begin
            r_irq_mask <= writedata[WIDTH-1:0];
         end
         // A capture on the same edge as a clear must survive.
         r_edge_capture <= (r_edge_capture & ~w_clear) | w_capture;
      end
   end

   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA: w_rd[WIDTH-1:0] = w_stable;
         ADDR_RSVD: w_rd            = '0;
         ADDR_MASK: w_rd[WIDTH-1:0] = r_irq_mask;
         ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge_capture;
      endcase
   end

   assign readdata       = w_rd;
   assign irq            = |(r_edge_capture & r_irq_mask);
   assign w_unused_wdata = ^writedata;

endmodule

`default_nettype wire
